// File: rtl/mips_avalon_arb_pkg.sv
// mips_avalon_arb_pkg: shared state type, default widths and the idle-cycle grant decision
package mips_avalon_arb_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  function automatic state_t grant(input logic rd_req, input logic rd_conflict, input logic wb_empty,
                                   input logic wb_full, input logic wb_pop, input logic starved);
    logic wr_ok, rd_ok;
    wr_ok = !wb_empty && !wb_pop;
    rd_ok = rd_req && !(rd_conflict && !wb_empty);
    return (wr_ok && (wb_full || (rd_req && rd_conflict) || starved)) ? WRITE :
           rd_ok ? READ : wr_ok ? WRITE : IDLE;
  endfunction
endpackage

// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: sequences cache reads and write-buffer drains onto one Avalon-MM port
module mips_avalon_arbiter
  import mips_avalon_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W/8-1:0] rd_byteenable,
  input  logic                rd_conflict,
  output logic                rd_done,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wb_empty,
  input  logic                wb_full,
  input  logic [ADDR_W-1:0]   wb_head_addr,
  input  logic [DATA_W-1:0]   wb_head_data,
  input  logic [DATA_W/8-1:0] wb_head_byteenable,
  output logic                wb_pop,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state, next;
  logic [SW-1:0] streak;
  logic done, rd_grant, wr_grant;
  assign busy = state != IDLE;
  assign done = busy && !avm_waitrequest;
  assign rd_grant = state == IDLE && next == READ;
  assign wr_grant = state == IDLE && next == WRITE;
  // next state: arbitrate while idle, otherwise leave once the slave accepts the transfer
  always_comb begin
    next = state;
    next = state == IDLE ? grant(rd_req, rd_conflict, wb_empty, wb_full, wb_pop, streak == SW'(STARVE_LIMIT)) :
           done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= next;
  end
  // Avalon command registers and completion pulses; commands only change on grant or completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avm_address <= '0;
      avm_read <= 1'b0;
      avm_write <= 1'b0;
      avm_writedata <= '0;
      avm_byteenable <= '0;
      rd_done <= 1'b0;
      rd_data <= '0;
      wb_pop <= 1'b0;
    end else begin
      rd_done <= state == READ && done;
      wb_pop <= state == WRITE && done;
      if (state == READ && done) rd_data <= avm_readdata;
      if (done) begin
        avm_read <= 1'b0;
        avm_write <= 1'b0;
      end
      if (rd_grant) begin
        avm_address <= rd_addr;
        avm_byteenable <= rd_byteenable;
        avm_read <= 1'b1;
      end
      if (wr_grant) begin
        avm_address <= wb_head_addr;
        avm_writedata <= wb_head_data;
        avm_byteenable <= wb_head_byteenable;
        avm_write <= 1'b1;
      end
    end
  end
  // consecutive reads served while writes wait; saturates so a write is forced at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) streak <= '0;
    else if (wb_empty || wr_grant) streak <= '0;
    else if (state == READ && done && streak != SW'(STARVE_LIMIT)) streak <= streak + SW'(1);
  end
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// tb_mips_avalon_arbiter: scoreboard bench with a delayed Avalon slave and a write-buffer model
module tb_mips_avalon_arbiter;
  localparam int READ_DELAY = 2;
  localparam logic [31:0] OFF = 32'hBFC0_0000;
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} txn_t;

  logic clk = 1'b0, rst = 1'b0;
  logic rd_req = 1'b0, rd_conflict = 1'b0, rd_done, wb_empty, wb_full = 1'b0, wb_pop;
  logic [31:0] rd_addr = '0, rd_data, wb_head_addr, wb_head_data;
  logic [3:0] rd_byteenable = 4'hF, wb_head_byteenable, avm_byteenable;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic avm_read, avm_write, avm_waitrequest, busy;

  mips_avalon_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_byteenable(rd_byteenable),
    .rd_conflict(rd_conflict), .rd_done(rd_done), .rd_data(rd_data), .wb_empty(wb_empty),
    .wb_full(wb_full), .wb_head_addr(wb_head_addr), .wb_head_data(wb_head_data),
    .wb_head_byteenable(wb_head_byteenable), .wb_pop(wb_pop), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .busy(busy));

  initial forever #5 clk = ~clk;

  // slave: stalls READ_DELAY cycles per transfer; unwritten words read as A000_0000 | index
  logic [31:0] mem [64];
  logic [63:0] wr_mask = '0;
  int wcnt = 0;
  assign avm_waitrequest = (avm_read || avm_write) && (wcnt < READ_DELAY);
  assign avm_readdata = wr_mask[avm_address[5:0]] ? mem[avm_address[5:0]] : (32'hA000_0000 | {26'd0, avm_address[5:0]});
  always @(posedge clk) begin
    if (avm_read || avm_write) begin
      if (wcnt < READ_DELAY) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        if (avm_write) begin
          mem[avm_address[5:0]] <= avm_writedata;
          wr_mask[avm_address[5:0]] <= 1'b1;
        end
      end
    end else wcnt <= 0;
  end

  // write buffer model
  logic [31:0] wa [16], wd [16];
  logic [4:0] hd = '0, tl = '0;
  assign wb_empty = hd == tl;
  assign wb_head_addr = wa[hd[3:0]];
  assign wb_head_data = wd[hd[3:0]];
  assign wb_head_byteenable = 4'hF;
  always @(posedge clk) if (wb_pop) hd <= hd + 5'd1;

  int checks = 0, errors = 0, pops = 0, n_txn = 0;
  txn_t expq[$];
  logic [31:0] rdq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compares every completed transfer, read return and pop against the scoreboard
  logic p_stb = 0, p_wait = 0, p_cmp = 0, p_done = 0, p_pop = 0;
  logic [31:0] p_addr = '0, p_wd = '0;
  logic [3:0] p_be = '0;
  always @(negedge clk) begin
    if (!rst) begin
      p_stb <= 0; p_wait <= 0; p_cmp <= 0; p_done <= 0; p_pop <= 0;
    end else begin
      if ((avm_read || avm_write) && p_stb && p_wait) begin
        check("hold_addr", avm_address, p_addr);
        check("hold_wdata", avm_writedata, p_wd);
        check("hold_be", avm_byteenable, p_be);
      end
      if (p_cmp) check("idle_gap", avm_read || avm_write, 0);
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_txn: got write=%0b addr %0h, none expected", avm_write, avm_address);
        end else begin
          check("txn_kind", avm_write, expq[0].w);
          check("txn_addr", avm_address, expq[0].a);
          check("txn_data", avm_write ? avm_writedata : avm_readdata, expq[0].d);
          expq.delete(0);
        end
        n_txn <= n_txn + 1;
      end
      if (rd_done) begin
        check("rd_done_pulse", p_done, 0);
        if (rdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_done: got data %0h, none expected", rd_data);
        end else begin
          check("rd_data", rd_data, rdq[0]);
          rdq.delete(0);
        end
      end
      if (wb_pop) begin
        pops <= pops + 1;
        check("wb_pop_pulse", p_pop, 0);
      end
      p_stb <= avm_read || avm_write;
      p_wait <= avm_waitrequest;
      p_cmp <= (avm_read || avm_write) && !avm_waitrequest;
      p_done <= rd_done;
      p_pop <= wb_pop;
      p_addr <= avm_address;
      p_wd <= avm_writedata;
      p_be <= avm_byteenable;
    end
  end

  task automatic push_wb(input logic [31:0] a, input logic [31:0] d);
    wa[tl[3:0]] = a;
    wd[tl[3:0]] = d;
    tl = tl + 5'd1;
  endtask

  task automatic exp_txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    expq.push_back({w, a, d});
    if (!w) rdq.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(expq.size() == 0 && rdq.size() == 0 && !busy && wb_empty) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_timeout"}, n >= 400, 0);
  endtask

  task automatic req_read(input logic [31:0] a);
    int n = 0;
    rd_addr = a;
    rd_req = 1'b1;
    do begin @(negedge clk); n++; end while (!avm_read && n < 100);
    rd_req = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d);
    exp_txn(0, a, d);
    req_read(a);
    wait_idle("read");
  endtask

  initial begin
    int n, rcnt, pops0, base;
    repeat (3) @(negedge clk);
    check("rst_addr", avm_address, 0);
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_be", avm_byteenable, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wb_pop", wb_pop, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // single read with the slave stalling
    exp_txn(0, OFF + 4, 32'hA000_0004);
    rd_addr = OFF + 4;
    rd_req = 1'b1;
    @(negedge clk);
    check("grant_latency", avm_read, 1);
    rcnt = int'(avm_read);
    rd_req = 1'b0;
    n = 0;
    while (!rd_done && n < 50) begin
      @(negedge clk);
      rcnt += int'(avm_read);
      n++;
    end
    check("read_strobe_cycles", rcnt, 3);
    wait_idle("t1");
    check("t1_no_pop", pops, 0);

    // drain of eight buffered writes, then read them back
    for (int i = 0; i < 8; i++) begin
      push_wb(OFF + i, i * i);
      exp_txn(1, OFF + i, i * i);
    end
    wait_idle("t2");
    check("t2_pops", pops, 8);
    for (int i = 0; i < 8; i++) do_read(OFF + i, i * i);

    // starvation: continuous reads with two buffered writes
    pops0 = pops;
    push_wb(OFF + 32'h10, 32'h1111);
    push_wb(OFF + 32'h11, 32'h2222);
    for (int i = 0; i < 4; i++) exp_txn(0, OFF + 32'h20, 32'hA000_0020);
    exp_txn(1, OFF + 32'h10, 32'h1111);
    for (int i = 0; i < 4; i++) exp_txn(0, OFF + 32'h20, 32'hA000_0020);
    exp_txn(1, OFF + 32'h11, 32'h2222);
    base = n_txn;
    rd_addr = OFF + 32'h20;
    rd_req = 1'b1;
    n = 0;
    while (n_txn < base + 10 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    rd_req = 1'b0;
    wait_idle("t3");
    check("t3_pops", pops - pops0, 2);

    // read-after-write conflict: write drains first, read sees new data
    push_wb(OFF + 3, 32'hDEAD_BEEF);
    exp_txn(1, OFF + 3, 32'hDEAD_BEEF);
    exp_txn(0, OFF + 3, 32'hDEAD_BEEF);
    rd_conflict = 1'b1;
    req_read(OFF + 3);
    rd_conflict = 1'b0;
    wait_idle("t4");

    // full write buffer beats a simultaneous read
    push_wb(OFF + 32'h30, 32'h1234_5678);
    exp_txn(1, OFF + 32'h30, 32'h1234_5678);
    exp_txn(0, OFF + 32'h31, 32'hA000_0031);
    wb_full = 1'b1;
    rd_addr = OFF + 32'h31;
    rd_req = 1'b1;
    @(negedge clk);
    check("full_priority_write", avm_write, 1);
    check("full_priority_read", avm_read, 0);
    wb_full = 1'b0;
    rd_req = 1'b0;
    req_read(OFF + 32'h31);
    wait_idle("t5");

    // reset while the slave stalls a write
    pops0 = pops;
    push_wb(OFF + 32'h3F, 32'h0000_0BAD);
    n = 0;
    do begin @(negedge clk); n++; end while (!avm_write && n < 50);
    check("t6_write_started", avm_write && avm_waitrequest, 1);
    #1 rst = 1'b0;
    #1;
    check("t6_async_write", avm_write, 0);
    check("t6_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_idle_after", busy, 0);
    check("t6_no_pop", pops, pops0);
    exp_txn(1, OFF + 32'h3F, 32'h0000_0BAD);
    wait_idle("t6");
    check("t6_retry_pop", pops, pops0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_avalon_arbiter.md
Name: mips_avalon_arbiter

Overview:
Single-master Avalon-MM sequencer that shares one memory port (mips_avalon_slave) between the cache read-miss path and the mips_cache_writebuffer drain path. It owns address/read/write/writedata/byteenable, which replaces the ad-hoc address mux between write-buffer and read sources. It applies read-priority arbitration with write-buffer-full override, read-after-write conflict handling and starvation protection.

Parameters:
STARVE_LIMIT, 4, consecutive read grants allowed while write buffer non-empty before one write is forced
ADDR_W, 32, address width
DATA_W, 32, data width (byteenable width DATA_W/8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rd_req  in  1  cache read request; held high until rd_done
rd_addr  in  ADDR_W  read address, sampled at grant
rd_byteenable  in  4  read byte lanes
rd_conflict  in  1  write buffer holds a pending entry matching rd_addr
rd_done  out  1  one-cycle pulse, rd_data valid
rd_data  out  DATA_W  captured read data
wb_empty  in  1  write buffer empty
wb_full  in  1  write buffer full
wb_head_addr  in  ADDR_W  oldest buffered write address
wb_head_data  in  DATA_W  oldest buffered write data
wb_head_byteenable  in  4  oldest buffered write byte lanes
wb_pop  out  1  one-cycle pulse, head entry retired
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read strobe
avm_write  out  1  Avalon write strobe
avm_writedata  out  DATA_W  Avalon write data
avm_byteenable  out  4  Avalon byte enables
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  slave read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- States: IDLE, READ, WRITE. All outputs registered except busy (decoded from state).
- Reset (rst low, async): state IDLE, streak counter 0, every output 0. Reset mid-transaction drops avm strobes immediately; no rd_done, no wb_pop.
- IDLE decision per cycle, first match wins:
  1. write eligible AND (wb_full OR (rd_req AND rd_conflict) OR streak == STARVE_LIMIT) -> WRITE
  2. rd_req AND NOT (rd_conflict AND NOT wb_empty) -> READ
  3. write eligible -> WRITE
  4. else stay IDLE
- Write eligible = NOT wb_empty AND NOT wb_pop. The head is stale during the pop cycle.
- rd_conflict is ignored when wb_empty is high.
- Grant edge: latch address/byteenable (and wb_head_data for writes) into avm registers and assert avm_read or avm_write. A request seen in cycle N has its strobe high from cycle N+1.
- READ/WRITE: hold all avm outputs constant while avm_waitrequest is high. The transfer completes on the rising edge where the strobe is high and avm_waitrequest is low. At that edge: strobe to 0, return to IDLE.
  - READ: rd_data <= avm_readdata; rd_done = 1 for the next cycle.
  - WRITE: wb_pop = 1 for the next cycle.
- Every transaction is followed by at least one IDLE cycle, so back-to-back grants are two cycles apart minimum.
- rd_req dropping mid-READ is ignored: the transfer completes and rd_done still pulses. A new read is granted only after rd_done.
- Streak counter: increments (saturating at STARVE_LIMIT) on each read completion while wb_empty is low. Clears on write grant or whenever wb_empty is high.
- rd_data holds its value until the next read completion.

Decomposition:
- Package mips_avalon_arb_pkg: state enum (IDLE/READ/WRITE), default widths, a grant-decision function (inputs: eligibility flags and streak; returns next state).
- No sub-module. The streak counter and registers stay inline.

Test Plan:
- Slave READ_DELAY=2, OFFSET 0xBFC00000. Single rd_req to 0xBFC00004, wb_empty=1 -> avm_read high for 3 cycles at constant address; rd_done one cycle after completion with the slave word; wb_pop never.
- Write buffer preloaded with 8 entries (data i*i, address OFFSET+i), no reads -> 8 writes in order, exactly 8 wb_pop pulses, at least one IDLE cycle between them; readback matches i*i.
- rd_req held continuously, wb_empty=0, wb_full=0, rd_conflict=0 -> 4 reads, then exactly 1 write, then 4 reads (STARVE_LIMIT=4).
- rd_req to 0xBFC00003 with rd_conflict=1 and one pending write to that address -> write completes first, then the read returns the newly written data.
- wb_full=1 and rd_req=1 in the same IDLE cycle -> WRITE granted first. rst pulled low while avm_waitrequest=1 in WRITE -> avm_write=0 asynchronously, no wb_pop, state IDLE after release.
